aes_kat_sequencer: RTL and testbench

// - Parametrised known-answer-test (KAT) sequencer for the AES datapath.
// - For each of NCH key-size channels, runs NVEC encrypt vectors, then NVEC decrypt vectors.
// - Handshakes with the AES core and the vector ROM, and compares each result to its expected block.
// - Latches one pass flag per channel and direction, and drives the board LEDs, gated by enable.
// - Sits between the AES core/ROM and the top-level LED pins; replaces fixed 3-mode pass wiring.

---
 rtl/aes_kat_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: runs the AES known-answer tests.
// For each key-size channel it runs NVEC encrypt vectors and then NVEC decrypt vectors.
// It compares each core result against the ROM expected block.
// It keeps one pass flag per channel and direction, and drives the pass LEDs.
// Optional build macro: AES_KAT_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; moves to S_INIT on the next cycle
// S_INIT  | clear indices and fail count, set all pass flags
// S_ISSUE | core_start is high for this one cycle
// S_WAIT  | indices held; waiting for core_done (or for the watchdog)
// S_CHECK | on a mismatch, clear the pass flag and bump fail_cnt
// S_NEXT  | advance vec -> dec -> ch; the last channel goes to S_DONE
// S_DONE  | flags are final; rerun restarts the run
module aes_kat_sequencer #(
  parameter  int NCH     = 3,
  parameter  int NVEC    = 4,
  parameter  int DATA_W  = 128,
  parameter  int TIMEOUT = 1024,
  localparam int CH_W    = (NCH  > 1) ? $clog2(NCH)  : 1,
  localparam int VEC_W   = (NVEC > 1) ? $clog2(NVEC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rerun,
  output logic              core_start,
  output logic [CH_W-1:0]   core_ch,
  output logic              core_dec,
  output logic [VEC_W-1:0]  core_vec,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  input  logic [DATA_W-1:0] exp_data,
  output logic [NCH-1:0]    enc_led,
  output logic [NCH-1:0]    dec_led,
  output logic              busy,
  output logic              all_done,
  output logic [7:0]        fail_cnt
);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NVEC - 1);

  if (NCH < 1 || NVEC < 1 || TIMEOUT < 1) begin : g_param_check
    $error("aes_kat_sequencer: NCH, NVEC and TIMEOUT must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state;
  logic           match_q;
  logic [NCH-1:0] pass_enc;
  logic [NCH-1:0] pass_dec;

`ifdef AES_KAT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Sequencer FSM: walks ch/dec/vec, handshakes with the core, and accumulates pass flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      core_start <= 1'b0;
      core_ch    <= '0;
      core_dec   <= 1'b0;
      core_vec   <= '0;
      busy       <= 1'b0;
      all_done   <= 1'b0;
      fail_cnt   <= 8'd0;
      match_q    <= 1'b0;
      pass_enc   <= '0;
      pass_dec   <= '0;
`ifdef AES_KAT_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          busy     <= 1'b1;
          all_done <= 1'b0;
          state    <= S_INIT;
        end
        S_INIT: begin
          core_ch    <= '0;
          core_dec   <= 1'b0;
          core_vec   <= '0;
          pass_enc   <= '1;
          pass_dec   <= '1;
          fail_cnt   <= 8'd0;
          busy       <= 1'b1;
          core_start <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
`ifdef AES_KAT_TIMEOUT_EN
          to_cnt <= TO_W'(TIMEOUT - 1);
`endif
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            match_q <= (core_result == exp_data);
            state   <= S_CHECK;
          end
`ifdef AES_KAT_TIMEOUT_EN
          // A silent core counts as a mismatch; a late answer then lands outside S_WAIT.
          else if (to_cnt == '0) begin
            match_q <= 1'b0;
            state   <= S_CHECK;
          end else begin
            to_cnt <= to_cnt - TO_W'(1);
          end
`endif
        end
        S_CHECK: begin
          if (!match_q) begin
            if (core_dec) pass_dec[core_ch] <= 1'b0;
            else          pass_enc[core_ch] <= 1'b0;
            if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (core_vec != VEC_LAST) begin
            core_vec   <= core_vec + VEC_W'(1);
            core_start <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            core_vec <= '0;
            if (!core_dec) begin
              core_dec   <= 1'b1;
              core_start <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              core_dec <= 1'b0;
              if (core_ch != CH_LAST) begin
                core_ch    <= core_ch + CH_W'(1);
                core_start <= 1'b1;
                state      <= S_ISSUE;
              end else begin
                core_ch  <= '0;
                busy     <= 1'b0;
                all_done <= 1'b1;
                state    <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (rerun) begin
            all_done <= 1'b0;
            busy     <= 1'b1;
            state    <= S_INIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // LED drivers are registered so that a change in enable shows one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_led <= '0;
      dec_led <= '0;
    end else begin
      enc_led <= (enable && all_done) ? pass_enc : '0;
      dec_led <= (enable && all_done) ? pass_dec : '0;
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Testbench for aes_kat_sequencer: uses directed runs against a behavioural core and a ROM model.
module tb_aes_kat_sequencer;
  localparam int NCH = 3, NVEC = 4, DATA_W = 128, TIMEOUT = 16, LAT = 3;

  logic clk = 1'b0;
  logic reset, enable, rerun;
  logic core_start, core_dec, core_done, busy, all_done;
  logic [1:0] core_ch, core_vec;
  logic [DATA_W-1:0] core_result, exp_data;
  logic [NCH-1:0] enc_led, dec_led;
  logic [7:0] fail_cnt;

  int n_chk = 0, n_pass = 0;
  int starts = 0, order_err = 0;
  int bad_ch = -1, bad_dec = 0, bad_vec = 0;
  int mute_ch = -1, mute_dec = 0, mute_vec = 0;

  always #5 clk = ~clk;

  aes_kat_sequencer #(.NCH(NCH), .NVEC(NVEC), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rerun(rerun),
    .core_start(core_start), .core_ch(core_ch), .core_dec(core_dec), .core_vec(core_vec),
    .core_done(core_done), .core_result(core_result), .exp_data(exp_data),
    .enc_led(enc_led), .dec_led(dec_led), .busy(busy), .all_done(all_done),
    .fail_cnt(fail_cnt)
  );

  function automatic logic [DATA_W-1:0] rom(input logic [1:0] ch, input logic dec,
                                            input logic [1:0] vec);
    return {96'h0123_4567_89AB_CDEF_FEDC_BA98, 6'd0, ch, 7'd0, dec, 6'd0, vec, 8'h5A};
  endfunction

  assign exp_data = rom(core_ch, core_dec, core_vec);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Core model: answers LAT cycles after core_start and checks the issue order.
  initial begin : core_model
    int resp, k;
    logic [1:0] m_ch, m_vec;
    logic m_dec, m_bad;
    resp = 0; m_ch = 0; m_vec = 0; m_dec = 0; m_bad = 0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (resp > 0) begin
        resp--;
        if (resp == 0) begin
          core_done = 1'b1;
          core_result = rom(m_ch, m_dec, m_vec) ^ (m_bad ? 128'h1 : 128'h0);
        end
      end
      if (core_start === 1'b1) begin
        k = starts;
        if (int'(core_ch) != k / (2 * NVEC) || int'(core_dec) != (k / NVEC) % 2 ||
            int'(core_vec) != k % NVEC)
          order_err++;
        starts++;
        m_ch = core_ch; m_dec = core_dec; m_vec = core_vec;
        m_bad = (int'(core_ch) == bad_ch && int'(core_dec) == bad_dec &&
                 int'(core_vec) == bad_vec);
        if (!(int'(core_ch) == mute_ch && int'(core_dec) == mute_dec &&
              int'(core_vec) == mute_vec))
          resp = LAT;
      end
    end
  end

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (all_done === 1'b1) break;
    end
    check(tag, 32'(all_done), 32'd1);
  endtask

  task automatic pulse_rerun();
    @(negedge clk); rerun = 1'b1;
    @(negedge clk); rerun = 1'b0;
  endtask

  initial begin : main
    reset = 1'b0; enable = 1'b1; rerun = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_all_done", 32'(all_done), 32'd0);
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_enc_led", 32'(enc_led), 32'd0);
    check("rst_dec_led", 32'(dec_led), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);

    // Run 1: every vector matches.
    starts = 0; order_err = 0;
    reset = 1'b1;
    wait_done("run1_done");
    check("run1_starts", 32'(starts), 32'd24);
    check("run1_order", 32'(order_err), 32'd0);
    @(negedge clk);
    check("run1_enc_led", 32'(enc_led), 32'b111);
    check("run1_dec_led", 32'(dec_led), 32'b111);
    check("run1_fail_cnt", 32'(fail_cnt), 32'd0);
    check("run1_busy", 32'(busy), 32'd0);

    // Run 2: a single mismatch on ch1, decrypt, vec2.
    bad_ch = 1; bad_dec = 1; bad_vec = 2;
    starts = 0; order_err = 0;
    pulse_rerun();
    check("rerun_clears_done", 32'(all_done), 32'd0);
    check("rerun_busy", 32'(busy), 32'd1);
    wait_done("run2_done");
    @(negedge clk);
    check("run2_starts", 32'(starts), 32'd24);
    check("run2_enc_led", 32'(enc_led), 32'b111);
    check("run2_dec_led", 32'(dec_led), 32'b101);
    check("run2_fail_cnt", 32'(fail_cnt), 32'd1);

    // enable gating: LEDs follow one cycle after each change of enable.
    enable = 1'b0; #1;
    check("en0_same_cycle", 32'(enc_led), 32'b111);
    @(negedge clk);
    check("en0_enc_led", 32'(enc_led), 32'b000);
    check("en0_dec_led", 32'(dec_led), 32'b000);
    enable = 1'b1;
    @(negedge clk);
    check("en1_enc_led", 32'(enc_led), 32'b111);
    check("en1_dec_led", 32'(dec_led), 32'b101);

    // Run 3: a rerun mid-run is ignored, and the flags are recomputed from scratch.
    bad_ch = -1;
    starts = 0; order_err = 0;
    pulse_rerun();
    repeat (20) @(negedge clk);
    pulse_rerun();
    check("midrun_busy", 32'(busy), 32'd1);
    wait_done("run3_done");
    @(negedge clk);
    check("run3_starts", 32'(starts), 32'd24);
    check("run3_order", 32'(order_err), 32'd0);
    check("run3_dec_led", 32'(dec_led), 32'b111);
    check("run3_fail_cnt", 32'(fail_cnt), 32'd0);

    // Reset while waiting on ch2, then a complete restart from ch0 vec0.
    pulse_rerun();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (core_ch == 2'd2 && core_start == 1'b0 && busy == 1'b1) break;
    end
    check("reach_ch2", 32'(core_ch), 32'd2);
    reset = 1'b0; #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ch", 32'(core_ch), 32'd0);
    check("midrst_enc_led", 32'(enc_led), 32'd0);
    repeat (5) @(negedge clk);
    starts = 0; order_err = 0;
    reset = 1'b1;
    wait_done("run4_done");
    @(negedge clk);
    check("run4_starts", 32'(starts), 32'd24);
    check("run4_order", 32'(order_err), 32'd0);
    check("run4_enc_led", 32'(enc_led), 32'b111);
    check("run4_dec_led", 32'(dec_led), 32'b111);

`ifdef AES_KAT_TIMEOUT_EN
    // The core never answers ch0 enc vec0, so the watchdog scores it as a mismatch.
    mute_ch = 0; mute_dec = 0; mute_vec = 0;
    starts = 0; order_err = 0;
    pulse_rerun();
    wait_done("to_done");
    @(negedge clk);
    check("to_starts", 32'(starts), 32'd24);
    check("to_enc_led", 32'(enc_led), 32'b110);
    check("to_dec_led", 32'(dec_led), 32'b111);
    check("to_fail_cnt", 32'(fail_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
